// File: rtl/psum_drain_if.sv
// psum_drain_if: row capture, register-file write and output beat signals.
// master drives rows/config/ready, slave is the drain block.
interface psum_drain_if #(
  parameter int N      = 8,
  parameter int LANES  = 2,
  parameter int PSUM_W = 32,
  parameter int OUT_W  = 8
);
  localparam int CW = $clog2(N);

  logic [N-1:0][PSUM_W-1:0]   psum_i;
  logic [N-1:0]               psum_valid_i;
  logic                       psum_ready_o;
  logic                       cfg_we_i;
  logic                       cfg_sel_i;
  logic [CW-1:0]              cfg_addr_i;
  logic [31:0]                cfg_data_i;
  logic [LANES-1:0][OUT_W-1:0] out_data_o;
  logic [CW-1:0]              out_col_o;
  logic                       out_last_o;
  logic                       out_valid_o;
  logic                       out_ready_i;

  modport master (
    output psum_i, psum_valid_i,
    output cfg_we_i, cfg_sel_i, cfg_addr_i, cfg_data_i,
    output out_ready_i,
    input  psum_ready_o,
    input  out_data_o, out_col_o, out_last_o, out_valid_o
  );

  modport slave (
    input  psum_i, psum_valid_i,
    input  cfg_we_i, cfg_sel_i, cfg_addr_i, cfg_data_i,
    input  out_ready_i,
    output psum_ready_o,
    output out_data_o, out_col_o, out_last_o, out_valid_o
  );
endinterface

// File: rtl/psum_drain.sv
// psum_drain: row buffer feeding a bias/scale/round/saturate drain pipeline.
// Define PSUM_DRAIN_RELU_EN to clamp negative results to 0 before saturation.
module psum_drain #(
  parameter int N      = 8,
  parameter int LANES  = 2,
  parameter int PSUM_W = 32,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 16,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  psum_drain_if.slave bus
);
  localparam int CW    = $clog2(N);
  localparam int AW    = $clog2(DEPTH);
  localparam int BEATS = N / LANES;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW    = ((PSUM_W > 32) ? PSUM_W : 32) + 1;
  localparam int MW    = SW + 32;
  localparam int RW    = MW + 1;

  localparam logic signed [RW-1:0] RND  = RW'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] MAXV = RW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = -MAXV - 1;

  typedef logic [N-1:0][PSUM_W-1:0] row_t;

  row_t          rows [DEPTH];
  row_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [KW-1:0] beat;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          stall;
  logic          issue;
  logic          last_beat;
  logic [CW-1:0] a_col_n;

  logic signed [31:0] bias  [N];
  logic signed [31:0] scale [N];

  assign full      = count == (AW+1)'(DEPTH);
  assign empty     = count == '0;
  assign push      = (&bus.psum_valid_i) && !full;
  assign stall     = bus.out_valid_o && !bus.out_ready_i;
  assign issue     = !empty && !stall;
  assign last_beat = beat == KW'(BEATS - 1);
  assign pop       = issue && last_beat;
  assign a_col_n   = CW'(int'(beat) * LANES);
  assign head      = rows[rd_ptr];

  assign bus.psum_ready_o = !full;

  // Row storage needs no reset: count/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) rows[wr_ptr] <= bus.psum_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      beat   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (issue) beat <= last_beat ? '0 : beat + KW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        bias[i]  <= '0;
        scale[i] <= 32'(1 << SHIFT);
      end
    end else if (bus.cfg_we_i) begin
      if (bus.cfg_sel_i) scale[bus.cfg_addr_i] <= bus.cfg_data_i;
      else bias[bus.cfg_addr_i] <= bus.cfg_data_i;
    end
  end

  logic          a_vld, b_vld, c_vld;
  logic          a_last, b_last, c_last;
  logic [CW-1:0] a_col, b_col, c_col;

  logic signed [PSUM_W-1:0] a_psum   [LANES];
  logic signed [31:0]       a_bias   [LANES];
  logic signed [SW-1:0]     b_sum    [LANES];
  logic signed [31:0]       b_scale  [LANES];
  logic signed [MW-1:0]     c_prod   [LANES];

  logic signed [PSUM_W-1:0] a_psum_n  [LANES];
  logic signed [31:0]       a_bias_n  [LANES];
  logic signed [SW-1:0]     b_sum_n   [LANES];
  logic signed [31:0]       b_scale_n [LANES];
  logic signed [MW-1:0]     c_prod_n  [LANES];

  logic [LANES-1:0][OUT_W-1:0] d_pack;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [RW-1:0] rsum;
    logic signed [RW-1:0] r;
    logic [OUT_W-1:0]     sat;

    assign a_psum_n[l]  = head[a_col_n + CW'(l)];
    assign a_bias_n[l]  = bias[a_col_n + CW'(l)];
    assign b_sum_n[l]   = SW'(a_psum[l]) + SW'(a_bias[l]);
    assign b_scale_n[l] = scale[a_col + CW'(l)];
    assign c_prod_n[l]  = MW'(b_sum[l]) * MW'(b_scale[l]);
    assign rsum         = RW'(c_prod[l]) + RND;

    always_comb begin
      r = rsum >>> SHIFT;
`ifdef PSUM_DRAIN_RELU_EN
      if (r < 0) r = '0;
`endif
      if (r > MAXV) sat = MAXV[OUT_W-1:0];
      else if (r < MINV) sat = MINV[OUT_W-1:0];
      else sat = r[OUT_W-1:0];
    end

    assign d_pack[l] = sat;
  end

  // A single stall freezes every stage so beats never slip or duplicate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld  <= 1'b0;
      b_vld  <= 1'b0;
      c_vld  <= 1'b0;
      a_last <= 1'b0;
      b_last <= 1'b0;
      c_last <= 1'b0;
      a_col  <= '0;
      b_col  <= '0;
      c_col  <= '0;
      for (int i = 0; i < LANES; i++) begin
        a_psum[i]  <= '0;
        a_bias[i]  <= '0;
        b_sum[i]   <= '0;
        b_scale[i] <= '0;
        c_prod[i]  <= '0;
      end
      bus.out_valid_o <= 1'b0;
      bus.out_data_o  <= '0;
      bus.out_col_o   <= '0;
      bus.out_last_o  <= 1'b0;
    end else if (!stall) begin
      a_vld  <= issue;
      a_col  <= a_col_n;
      a_last <= issue && last_beat;
      b_vld  <= a_vld;
      b_col  <= a_col;
      b_last <= a_last;
      c_vld  <= b_vld;
      c_col  <= b_col;
      c_last <= b_last;
      for (int i = 0; i < LANES; i++) begin
        a_psum[i]  <= a_psum_n[i];
        a_bias[i]  <= a_bias_n[i];
        b_sum[i]   <= b_sum_n[i];
        b_scale[i] <= b_scale_n[i];
        c_prod[i]  <= c_prod_n[i];
      end
      bus.out_valid_o <= c_vld;
      bus.out_data_o  <= d_pack;
      bus.out_col_o   <= c_col;
      bus.out_last_o  <= c_last;
    end
  end
endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed checks of latency, arithmetic, saturation,
// backpressure, full buffer and reset for psum_drain.
module tb_psum_drain;
  localparam int N      = 8;
  localparam int LANES  = 2;
  localparam int PSUM_W = 32;
  localparam int OUT_W  = 8;
  localparam int SHIFT  = 16;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   row [N];

  always #5 clk = ~clk;

  psum_drain_if #(
    .N(N), .LANES(LANES), .PSUM_W(PSUM_W), .OUT_W(OUT_W)
  ) bus ();

  psum_drain #(
    .N(N), .LANES(LANES), .PSUM_W(PSUM_W),
    .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ln(input int v);
    int t;
    t = v;
`ifdef PSUM_DRAIN_RELU_EN
    if (t < 0) t = 0;
`endif
    return t[7:0];
  endfunction

  function automatic logic [15:0] bt(input int lo, input int hi);
    return {ln(hi), ln(lo)};
  endfunction

  task automatic push_row(input logic [N-1:0] vmask);
    for (int c = 0; c < N; c++) bus.psum_i[c] = PSUM_W'(row[c]);
    bus.psum_valid_i = vmask;
    tick;
    bus.psum_valid_i = '0;
  endtask

  task automatic cfg(input logic sel, input int addr, input int data);
    bus.cfg_we_i   = 1'b1;
    bus.cfg_sel_i  = sel;
    bus.cfg_addr_i = 3'(addr);
    bus.cfg_data_i = 32'(data);
    tick;
    bus.cfg_we_i   = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [15:0] data,
                             input int col, input logic last);
    int n;
    n = 0;
    while (bus.out_valid_o !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_valid"}, 64'(bus.out_valid_o), 64'(1));
    chk({tag, "_data"}, 64'(bus.out_data_o), 64'(data));
    chk({tag, "_col"}, 64'(bus.out_col_o), 64'(col));
    chk({tag, "_last"}, 64'(bus.out_last_o), 64'(last));
    tick;
  endtask

  initial begin
    bus.psum_i       = '0;
    bus.psum_valid_i = '0;
    bus.cfg_we_i     = 1'b0;
    bus.cfg_sel_i    = 1'b0;
    bus.cfg_addr_i   = '0;
    bus.cfg_data_i   = '0;
    bus.out_ready_i  = 1'b1;
    tick;
    tick;
    chk("rst_valid", 64'(bus.out_valid_o), 64'(0));
    chk("rst_data", 64'(bus.out_data_o), 64'(0));
    chk("rst_col", 64'(bus.out_col_o), 64'(0));
    chk("rst_last", 64'(bus.out_last_o), 64'(0));
    chk("rst_ready", 64'(bus.psum_ready_o), 64'(1));
    rst_n = 1'b1;
    tick;

    // identity row with exact latency
    for (int c = 0; c < N; c++) row[c] = c - 3;
    push_row('1);
    tick;
    tick;
    tick;
    chk("id_early", 64'(bus.out_valid_o), 64'(0));
    tick;
    chk("id_lat", 64'(bus.out_valid_o), 64'(1));
    expect_beat("id_b0", bt(-3, -2), 0, 1'b0);
    expect_beat("id_b1", bt(-1, 0), 2, 1'b0);
    expect_beat("id_b2", bt(1, 2), 4, 1'b0);
    expect_beat("id_b3", bt(3, 4), 6, 1'b1);
    chk("id_end", 64'(bus.out_valid_o), 64'(0));

    // partial valid must be ignored
    for (int c = 0; c < N; c++) row[c] = c + 50;
    push_row(8'h7F);
    repeat (6) tick;
    chk("part_valid", 64'(bus.out_valid_o), 64'(0));
    chk("part_ready", 64'(bus.psum_ready_o), 64'(1));

    // bias 10, scale 0.5 on column 0
    cfg(1'b0, 0, 10);
    cfg(1'b1, 0, 32'h8000);
    for (int c = 0; c < N; c++) row[c] = c;
    row[0] = 5;
    push_row('1);
    row[0] = -16;
    push_row('1);
    expect_beat("bs_a0", bt(8, 1), 0, 1'b0);
    expect_beat("bs_a1", bt(2, 3), 2, 1'b0);
    expect_beat("bs_a2", bt(4, 5), 4, 1'b0);
    expect_beat("bs_a3", bt(6, 7), 6, 1'b1);
    expect_beat("bs_b0", bt(-3, 1), 0, 1'b0);
    expect_beat("bs_b1", bt(2, 3), 2, 1'b0);
    expect_beat("bs_b2", bt(4, 5), 4, 1'b0);
    expect_beat("bs_b3", bt(6, 7), 6, 1'b1);

    // saturation with identity scale
    cfg(1'b0, 0, 0);
    cfg(1'b1, 0, 65536);
    row[0] = 0;    row[1] = 0;
    row[2] = 1000; row[3] = -1000;
    row[4] = 100;  row[5] = -100;
    row[6] = 200;  row[7] = -200;
    push_row('1);
    expect_beat("sat_b0", bt(0, 0), 0, 1'b0);
    expect_beat("sat_b1", bt(127, -128), 2, 1'b0);
    expect_beat("sat_b2", bt(100, -100), 4, 1'b0);
    expect_beat("sat_b3", bt(127, -128), 6, 1'b1);

    // backpressure mid-row
    for (int c = 0; c < N; c++) row[c] = 11 + c;
    push_row('1);
    expect_beat("bp_b0", bt(11, 12), 0, 1'b0);
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", 64'(bus.out_valid_o), 64'(1));
      chk("bp_hold_data", 64'(bus.out_data_o), 64'(bt(13, 14)));
      chk("bp_hold_col", 64'(bus.out_col_o), 64'(2));
      tick;
    end
    bus.out_ready_i = 1'b1;
    expect_beat("bp_b1", bt(13, 14), 2, 1'b0);
    expect_beat("bp_b2", bt(15, 16), 4, 1'b0);
    expect_beat("bp_b3", bt(17, 18), 6, 1'b1);
    chk("bp_end", 64'(bus.out_valid_o), 64'(0));

    // full buffer with downstream stalled
    bus.out_ready_i = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int c = 0; c < N; c++) row[c] = 20 * r + c;
      push_row('1);
    end
    chk("full_ready", 64'(bus.psum_ready_o), 64'(0));
    for (int c = 0; c < N; c++) row[c] = 100 + c;
    push_row('1);
    chk("full_pop_ready", 64'(bus.psum_ready_o), 64'(1));
    repeat (3) tick;
    chk("full_hold_valid", 64'(bus.out_valid_o), 64'(1));
    chk("full_hold_data", 64'(bus.out_data_o), 64'(bt(0, 1)));
    bus.out_ready_i = 1'b1;
    for (int r = 0; r < DEPTH; r++) begin
      for (int k = 0; k < N / LANES; k++) begin
        expect_beat($sformatf("full_r%0d_b%0d", r, k),
                    bt(20 * r + 2 * k, 20 * r + 2 * k + 1),
                    2 * k, k == N / LANES - 1);
      end
    end
    chk("full_extra", 64'(bus.out_valid_o), 64'(0));

    // reset during beat 1
    cfg(1'b0, 1, 50);
    for (int c = 0; c < N; c++) row[c] = c;
    push_row('1);
    expect_beat("rm_b0", bt(0, 51), 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rm_valid", 64'(bus.out_valid_o), 64'(0));
    chk("rm_data", 64'(bus.out_data_o), 64'(0));
    chk("rm_col", 64'(bus.out_col_o), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick;
    chk("rm_ready", 64'(bus.psum_ready_o), 64'(1));
    repeat (3) tick;
    chk("rm_flushed", 64'(bus.out_valid_o), 64'(0));
    for (int c = 0; c < N; c++) row[c] = 30 + c;
    push_row('1);
    expect_beat("rm_n0", bt(30, 31), 0, 1'b0);
    expect_beat("rm_n1", bt(32, 33), 2, 1'b0);
    expect_beat("rm_n2", bt(34, 35), 4, 1'b0);
    expect_beat("rm_n3", bt(36, 37), 6, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
